// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_ZERO_REG   = 31;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file access bus: read addresses/data, write port, clear request, ready.
interface regfile_mp_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2
);

  logic [NUM_READ*ADDR_WIDTH-1:0] RA;
  logic [NUM_READ*DATA_WIDTH-1:0] Bus;
  logic [ADDR_WIDTH-1:0]          RW;
  logic [DATA_WIDTH-1:0]          BusW;
  logic                           RegWr;
  logic                           ClearReq;
  logic                           Ready;

  modport master (
    output RA, RW, BusW, RegWr, ClearReq,
    input  Bus, Ready
  );

  modport slave (
    input  RA, RW, BusW, RegWr, ClearReq,
    output Bus, Ready
  );

endinterface

// File: rtl/regfile_read_port.sv
// One read port: selects zero, forwarded write data, or stored array data.
module regfile_read_port #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 31,
  parameter bit          HAS_ZERO   = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  input  logic [DATA_WIDTH-1:0] arrData,
  input  logic                  ready,
  input  logic                  fwdEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic [DATA_WIDTH-1:0] rdData
);

  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);

  // Priority: not ready, hardwired zero, same-cycle forward, then the array.
  always_comb begin
    rdData = '0;
    if (!ready) begin
      rdData = '0;
    end else if (HAS_ZERO && (rdAddr == ZeroAddr)) begin
      rdData = '0;
    end else if (fwdEn && (wrAddr == rdAddr)) begin
      rdData = wrData;
    end else begin
      rdData = arrData;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with zero register, write
// forwarding and a post-reset / on-request clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned ZERO_REG   = DEF_ZERO_REG,
  parameter bit          HAS_ZERO   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input logic         Clk,
  input logic         Reset,
  regfile_mp_if.slave rf
);

  localparam int unsigned           DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state;
  state_t                  stateNext;
  logic [ADDR_WIDTH-1:0]   clrIdx;
  logic [DATA_WIDTH-1:0]   regs [DEPTH];

  logic                    ready;
  logic                    zeroHit;
  logic                    userWr;
  logic                    wrEn;
  logic [ADDR_WIDTH-1:0]   wrAddr;
  logic [DATA_WIDTH-1:0]   wrData;
  logic                    fwdEn;
  logic [DATA_WIDTH-1:0]   rdData [NUM_READ];

  assign ready    = (state == READY);
  assign rf.Ready = ready;

  // State register; reset always restarts the sweep.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= CLEAR;
    end else begin
      state <= stateNext;
    end
  end

  // Next state: sweep ends on the last index; a clear request restarts it.
  always_comb begin
    stateNext = state;
    case (state)
      CLEAR:   if (clrIdx == LastIdx) stateNext = READY;
      READY:   if (rf.ClearReq)       stateNext = CLEAR;
      default: stateNext = CLEAR;
    endcase
  end

  // Sweep index: counts through CLEAR, rolling to zero exactly on the exit edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clrIdx <= '0;
    end else if (state == CLEAR) begin
      clrIdx <= clrIdx + ADDR_WIDTH'(1);
    end else if (rf.ClearReq) begin
      clrIdx <= '0;
    end
  end

  // A user write is legal only in READY, without a competing clear, off the zero register.
  always_comb begin
    zeroHit = HAS_ZERO && (rf.RW == ZeroAddr);
    userWr  = ready && rf.RegWr && !rf.ClearReq && !zeroHit;
    fwdEn   = BYPASS && userWr;
  end

  // Single write path: sweep zeroing muxed against the user write.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = rf.RW;
    wrData = rf.BusW;
    if (state == CLEAR) begin
      wrEn   = 1'b1;
      wrAddr = clrIdx;
      wrData = '0;
    end else begin
      wrEn   = userWr;
    end
  end

  // Storage array; contents are only ever cleared through the sweep.
  always_ff @(posedge Clk) begin
    if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : gRead
    logic [ADDR_WIDTH-1:0] addr;
    assign addr = rf.RA[i*ADDR_WIDTH +: ADDR_WIDTH];

    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .HAS_ZERO   (HAS_ZERO)
    ) uPort (
      .rdAddr  (addr),
      .arrData (regs[addr]),
      .ready   (ready),
      .fwdEn   (fwdEn),
      .wrAddr  (rf.RW),
      .wrData  (rf.BusW),
      .rdData  (rdData[i])
    );
  end

  // Pack per-port read data onto the flat output bus.
  always_comb begin
    rf.Bus = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      rf.Bus[i*DATA_WIDTH +: DATA_WIDTH] = rdData[i];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 4-port zero/bypass instance and a 2-port plain instance.
module tb_regfile_mp;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  regfile_mp_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(4)) ifA ();
  regfile_mp_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(2)) ifB ();

  regfile_mp #(
    .DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(4),
    .ZERO_REG(31), .HAS_ZERO(1'b1), .BYPASS(1'b1)
  ) dutA (
    .Clk   (Clk),
    .Reset (Reset),
    .rf    (ifA.slave)
  );

  regfile_mp #(
    .DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(2),
    .ZERO_REG(31), .HAS_ZERO(1'b0), .BYPASS(1'b0)
  ) dutB (
    .Clk   (Clk),
    .Reset (Reset),
    .rf    (ifB.slave)
  );

  typedef struct {
    string        tag;
    logic [255:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned asserts  = 0;
  int unsigned failures = 0;

  function automatic void expectVal(string tag, logic [255:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endfunction

  task automatic check(logic [255:0] obs);
    exp_t e;
    asserts++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setRead(logic [4:0] a);
    for (int i = 0; i < 4; i++) ifA.RA[i*5 +: 5] = a;
    for (int i = 0; i < 2; i++) ifB.RA[i*5 +: 5] = a;
  endtask

  task automatic setWrite(logic en, logic [4:0] rw, logic [63:0] d);
    ifA.RegWr = en; ifA.RW = rw; ifA.BusW = d;
    ifB.RegWr = en; ifB.RW = rw; ifB.BusW = d;
  endtask

  task automatic setClear(logic c);
    ifA.ClearReq = c;
    ifB.ClearReq = c;
  endtask

  task automatic checkReady(string tag, logic [1:0] exp);
    expectVal(tag, 256'(exp));
    check(256'({ifA.Ready, ifB.Ready}));
  endtask

  task automatic checkBus(string tagA, logic [255:0] expA, string tagB, logic [127:0] expB);
    expectVal(tagA, expA);
    check(256'(ifA.Bus));
    expectVal(tagB, 256'(expB));
    check(256'(ifB.Bus));
  endtask

  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] V1234 = 64'h1234;

  initial begin
    Reset = 1'b1;
    setRead(5'd0);
    setWrite(1'b0, 5'd0, 64'd0);
    setClear(1'b0);

    // Reset state
    repeat (3) tick();
    checkReady("reset_ready", 2'b00);
    checkBus("reset_busA", '0, "reset_busB", '0);

    // Sweep after release: not ready for 32 edges, then ready
    Reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      setRead(5'(k));
      #1;
      checkReady("sweep_ready_low", 2'b00);
      checkBus("sweep_busA_zero", '0, "sweep_busB_zero", '0);
      tick();
    end
    #1;
    checkReady("sweep_ready_high", 2'b11);

    // Every entry reads zero after the sweep
    for (int a = 0; a < 32; a++) begin
      setRead(5'(a));
      #1;
      checkBus("cleared_busA", '0, "cleared_busB", '0);
      tick();
    end

    // Same-cycle forwarding on A, old value on B
    setRead(5'd5);
    setWrite(1'b1, 5'd5, DEAD);
    #1;
    checkBus("bypass_same_A", {4{DEAD}}, "nobypass_same_B", '0);
    tick();
    setWrite(1'b0, 5'd0, 64'd0);
    #1;
    checkBus("write_after_A", {4{DEAD}}, "write_after_B", {2{DEAD}});
    tick();

    // Zero register on A; ordinary register on B
    setRead(5'd31);
    setWrite(1'b1, 5'd31, ONES);
    #1;
    checkBus("zero_same_A", '0, "r31_same_B", '0);
    tick();
    setWrite(1'b0, 5'd0, 64'd0);
    #1;
    checkBus("zero_after_A", '0, "r31_after_B", {2{ONES}});
    tick();

    // All ports reading one register
    setWrite(1'b1, 5'd7, V1234);
    tick();
    setWrite(1'b0, 5'd0, 64'd0);
    setRead(5'd7);
    #1;
    checkBus("allports_A", {4{V1234}}, "allports_B", {2{V1234}});
    tick();

    // Load regs 1..3
    for (int v = 1; v <= 3; v++) begin
      setWrite(1'b1, 5'(v), 64'(v));
      tick();
    end
    setWrite(1'b0, 5'd0, 64'd0);
    for (int i = 0; i < 4; i++) ifA.RA[i*5 +: 5] = 5'(i + 1);
    for (int i = 0; i < 2; i++) ifB.RA[i*5 +: 5] = 5'(i + 1);
    #1;
    checkBus("load_A", {64'd0, 64'd3, 64'd2, 64'd1}, "load_B", {64'd2, 64'd1});
    tick();

    // Clear wins over simultaneous write; no forwarding of the dropped write
    setWrite(1'b1, 5'd4, 64'hABCD);
    setClear(1'b1);
    #1;
    checkBus("clear_wr_noforward_A", {64'd0, 64'd3, 64'd2, 64'd1},
             "clear_wr_B", {64'd2, 64'd1});
    tick();
    setClear(1'b0);
    for (int k = 0; k < 32; k++) begin
      setClear(k == 10);
      if (k >= 1) setWrite(1'b1, 5'(k - 1), 64'h5A5A_5A5A_5A5A_5A5A);
      #1;
      checkReady("clear_sweep_ready_low", 2'b00);
      tick();
    end
    setClear(1'b0);
    setWrite(1'b0, 5'd0, 64'd0);
    #1;
    checkReady("clear_sweep_ready_high", 2'b11);
    checkBus("clear_regs_A", '0, "clear_regs_B", '0);
    tick();
    for (int a = 0; a < 32; a++) begin
      setRead(5'(a));
      #1;
      checkBus("clear_dropped_A", '0, "clear_dropped_B", '0);
      tick();
    end

    // Reset mid-sweep at index 10 restarts a full 32-edge sweep
    setWrite(1'b1, 5'd3, V1234);
    tick();
    setWrite(1'b0, 5'd0, 64'd0);
    setClear(1'b1);
    tick();
    setClear(1'b0);
    repeat (10) tick();
    Reset = 1'b1;
    #3;
    checkReady("midreset_ready", 2'b00);
    #2;
    Reset = 1'b0;
    setRead(5'd3);
    for (int k = 0; k < 32; k++) begin
      setWrite(1'b1, 5'd3, ONES);
      #1;
      checkReady("midreset_ready_low", 2'b00);
      tick();
    end
    setWrite(1'b0, 5'd0, 64'd0);
    #1;
    checkReady("midreset_ready_high", 2'b11);
    checkBus("midreset_r3_A", '0, "midreset_r3_B", '0);
    tick();

    asserts++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file, the next generation of the datapath register file in the single-cycle core. It adds configurable width, depth and read-port count, same-cycle write-to-read forwarding, and a hardwired zero register at a configurable index. It also clears every register to zero after reset or on request, using a sweep state machine. It sits between decode (register addresses) and the ALU/operand muxes, with the write-back bus feeding BusW.

## Interface
- DATA_WIDTH, 64: register width in bits
- ADDR_WIDTH, 5: address width; depth = 2**ADDR_WIDTH
- NUM_READ, 2: number of independent read ports (1..4)
- ZERO_REG, 31: index of the hardwired-zero register
- HAS_ZERO, 1: 1 = ZERO_REG reads 0 and ignores writes; 0 = ordinary register
- BYPASS, 1: 1 = same-cycle write data forwarded to matching read ports
- Clk  input  1  clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-high
- RA  input  NUM_READ*ADDR_WIDTH  read addresses; port i is bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- Bus  output  NUM_READ*DATA_WIDTH  read data; port i is bits [i*DATA_WIDTH +: DATA_WIDTH]
- RW  input  ADDR_WIDTH  write address
- BusW  input  DATA_WIDTH  write data
- RegWr  input  1  write enable
- ClearReq  input  1  single-cycle pulse; starts a clear sweep
- Ready  output  1  high when the file accepts writes and returns stored data

## Operation
- State machine has two states.
  - CLEAR: a counter ClrIdx writes zero to entry ClrIdx each cycle, incrementing 0 to 2**ADDR_WIDTH-1. After the last entry it goes to READY.
  - READY: normal operation.
- Reset asserted, asynchronously: state = CLEAR, ClrIdx = 0, Ready = 0. Array contents are not reset directly; the sweep clears them.
- Reset asserted mid-sweep: the sweep restarts at ClrIdx = 0.
- ClearReq in READY: next state is CLEAR with ClrIdx = 0. ClearReq in CLEAR is ignored; the sweep does not restart.
- Writes: on a rising edge with RegWr=1 and Ready=1, registers[RW] <= BusW.
  - Writes are dropped while Ready=0.
  - Writes are dropped when HAS_ZERO=1 and RW==ZERO_REG.
  - Simultaneous RegWr and ClearReq in READY: the write is dropped and the clear wins.
- Reads are combinational per port i:
  - Ready=0: Bus[i] = 0.
  - HAS_ZERO=1 and RA[i]==ZERO_REG: Bus[i] = 0.
  - BYPASS=1, RegWr=1, Ready=1, ClearReq=0, RW==RA[i], and RW is not the zero register: Bus[i] = BusW.
  - Otherwise: Bus[i] = registers[RA[i]].
- Any number of read ports may address the same register.

## Timing
- Reset values: Ready=0, Bus=0 on all ports, ClrIdx=0, state=CLEAR.
- After Reset deasserts, the sweep takes exactly 2**ADDR_WIDTH rising edges. Ready rises after the edge that clears the last entry (cycle 32 for the default depth).
- Read latency is 0 cycles (combinational).
- A write becomes visible through the array one edge after commit. With BYPASS=1 it is also visible in the same cycle. With BYPASS=0 a same-cycle read returns the old value.
- ClearReq sampled high at edge k: Ready=0 from just after edge k through the 2**ADDR_WIDTH sweep edges.
- ClrIdx wraps only at the CLEAR-to-READY transition; it never wraps inside CLEAR.

## Structure
- Shared package regfile_pkg holds:
  - the state enum: CLEAR, READY
  - default width constants: DATA_WIDTH 64, ADDR_WIDTH 5
  - ZERO_REG default 31
- One sub-module, regfile_read_port, instantiated NUM_READ times. It does the zero/forward/array select for a single port.
- Storage is a plain array in the top module with a single write path; the sweep and the normal write are muxed onto it.

## Test plan
- Reset, then idle: Ready=0 and every Bus port = 0 for 32 edges; Ready=1 after edge 32; reading all 32 addresses returns 0.
- Ready=1, write RW=5, BusW=64'hDEAD_BEEF_0000_0001 with RA0=5 in the same cycle: BYPASS=1 gives Bus0 = that value in the same cycle; BYPASS=0 gives 0 in the same cycle and the value after the edge.
- Write RW=31, BusW=64'hFFFF_FFFF_FFFF_FFFF with HAS_ZERO=1: read RA=31 returns 0 in the same cycle and after. With HAS_ZERO=0 the read returns all ones.
- Load regs 1..3 with 1, 2, 3; pulse ClearReq together with RegWr to RW=4: Ready drops after the edge, reg 4 is never written, and after 32 edges regs 1..4 read 0.
- Assert Reset at ClrIdx=10 mid-sweep, release: Ready rises exactly 32 edges after release. Writes attempted during CLEAR are all dropped and read back 0.
- NUM_READ=4, all RA=7 after writing 64'h1234: all four Bus ports equal 64'h1234 simultaneously.
